// File: rtl/proc_pkg.sv
// ----------------------------------------------------------------------------
// proc_pkg
// Shared types and constants for the processor data-port blocks.
//   dmc_state_t : data_mem_ctrl FSM state encoding
//   DATA_W      : processor data / RAM word width
//   WAIT_W      : width of the wait-state counter
// ----------------------------------------------------------------------------
package proc_pkg;

    localparam int DATA_W = 16;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } dmc_state_t;

    // True when the word address fits in an addrW-bit RAM (upper bits all zero).
    function automatic logic addrInRange(input logic [DATA_W-1:0] addr, input int addrW);
        return ((addr >> addrW) == '0);
    endfunction

endpackage

// File: rtl/data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// data_mem_ctrl
// Bridges the processor data port to a synchronous data RAM with a one-cycle
// registered read. One request is latched at a time, the RAM is driven from
// registers, WAIT_CYCLES wait states follow the RAM access, and DataDone tells
// the processor when the access has completed.
//
// Ports
//   Clock      in   system clock, all state on the rising edge
//   Reset      in   synchronous, active-high
//   DataAddr   in   [15:0] processor word address, sampled at accept
//   DataOut    in   [15:0] processor write data, sampled at accept
//   WriteData  in   write request (level)
//   ReadData   in   read request (level)
//   DataIn     out  [15:0] read data, valid while DataDone=1 after a read
//   DataDone   out  1 = idle or access complete, 0 = access in flight
//   mem_addr   out  [ADDR_W-1:0] RAM word address (registered)
//   mem_wdata  out  [15:0] RAM write data (registered)
//   mem_wren   out  RAM write enable, one cycle per in-range write
//   mem_rdata  in   [15:0] RAM read data, valid one edge after mem_addr
//   proto_err  out  sticky: RD+WR together or out-of-range address seen
// ----------------------------------------------------------------------------
module data_mem_ctrl
    import proc_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] DataAddr,
    input  logic [DATA_W-1:0] DataOut,
    input  logic              WriteData,
    input  logic              ReadData,
    output logic [DATA_W-1:0] DataIn,
    output logic              DataDone,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              proto_err
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

    dmc_state_t        state;
    logic [WAIT_W-1:0] waitCount;
    logic              opRead;      // latched op is a read (write wins on conflict)
    logic              opInRange;   // latched address was inside the RAM

    logic request;
    logic inRange;

    assign request = WriteData | ReadData;
    assign inRange = addrInRange(DataAddr, ADDR_W);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            waitCount <= '0;
            opRead    <= 1'b0;
            opInRange <= 1'b0;
            DataIn    <= '0;
            DataDone  <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wren  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (request) begin
                        state     <= ACCESS;
                        DataDone  <= 1'b0;
                        mem_addr  <= DataAddr[ADDR_W-1:0];
                        mem_wdata <= DataOut;
                        // Out-of-range writes still run the full sequence but never touch the RAM.
                        mem_wren  <= WriteData & inRange;
                        opRead    <= ~WriteData;
                        opInRange <= inRange;
                        if ((WriteData & ReadData) | ~inRange) begin
                            proto_err <= 1'b1;
                        end
                    end else begin
                        state    <= IDLE;
                        DataDone <= 1'b1;
                    end
                end

                // RAM samples mem_addr (and commits the write) on the edge leaving ACCESS.
                ACCESS: begin
                    mem_wren  <= 1'b0;
                    waitCount <= WAIT_INIT;
                    state     <= WAIT;
                end

                WAIT: begin
                    if (waitCount != '0) begin
                        waitCount <= waitCount - 1'b1;
                    end else begin
                        if (opRead) begin
                            DataIn <= opInRange ? mem_rdata : '0;
                        end
                        state    <= DONE;
                        DataDone <= 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    DataDone <= 1'b1;
                    mem_wren <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Three controller instances (WAIT_CYCLES = 1, 0, 15), each with its own
// behavioural RAM. Stimulus pushes the expected completion into a per-instance
// queue; a monitor on the falling edge pops and compares whenever DataDone
// rises, measuring latency and write-enable pulses along the way.
// ----------------------------------------------------------------------------
module tb_data_mem_ctrl;

    localparam int N = 3;

    typedef struct {
        logic        chk;    // compare DataIn (reads only)
        logic [15:0] data;
        logic        err;
        int          wren;   // expected number of mem_wren cycles
    } exp_t;

    logic        Clock;
    logic        Reset;
    logic [15:0] dataAddr  [N];
    logic [15:0] dataOut   [N];
    logic        writeData [N];
    logic        readData  [N];
    logic [15:0] dataIn    [N];
    logic        dataDone  [N];
    logic [11:0] memAddr   [N];
    logic [15:0] memWdata  [N];
    logic        memWren   [N];
    logic        protoErr  [N];

    int   errors = 0;
    int   checks = 0;
    exp_t expQ [N][$];

    function automatic int wcOf(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 15);
    endfunction

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            localparam int WC = (gi == 0) ? 1 : ((gi == 1) ? 0 : 15);
            logic [15:0] ram [0:4095];
            logic [15:0] rdata;

            data_mem_ctrl #(.ADDR_W(12), .WAIT_CYCLES(WC)) u_dut (
                .Clock     (Clock),
                .Reset     (Reset),
                .DataAddr  (dataAddr[gi]),
                .DataOut   (dataOut[gi]),
                .WriteData (writeData[gi]),
                .ReadData  (readData[gi]),
                .DataIn    (dataIn[gi]),
                .DataDone  (dataDone[gi]),
                .mem_addr  (memAddr[gi]),
                .mem_wdata (memWdata[gi]),
                .mem_wren  (memWren[gi]),
                .mem_rdata (rdata),
                .proto_err (protoErr[gi])
            );

            always @(posedge Clock) begin
                if (memWren[gi]) ram[memAddr[gi]] <= memWdata[gi];
                rdata <= ram[memAddr[gi]];
            end
        end
    endgenerate

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end else begin
            $display("ok   %s: %h at %0t", name, act, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int   lowCnt   [N];
    int   wrenCnt  [N];
    logic prevDone [N];

    always @(negedge Clock) begin
        for (int k = 0; k < N; k++) begin
            if (Reset) begin
                lowCnt[k]   = 0;
                wrenCnt[k]  = 0;
                prevDone[k] = 1'b1;
            end else begin
                if (!dataDone[k]) begin
                    lowCnt[k]++;
                    if (memWren[k]) wrenCnt[k]++;
                end else if (!prevDone[k]) begin
                    if (expQ[k].size() == 0) begin
                        check($sformatf("u%0d unexpected completion", k), 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = expQ[k].pop_front();
                        check($sformatf("u%0d latency", k), lowCnt[k], 2 + wcOf(k));
                        check($sformatf("u%0d wren cycles", k), wrenCnt[k], e.wren);
                        check($sformatf("u%0d proto_err", k), {31'd0, protoErr[k]}, {31'd0, e.err});
                        if (e.chk) check($sformatf("u%0d DataIn", k), {16'd0, dataIn[k]}, {16'd0, e.data});
                    end
                    lowCnt[k]  = 0;
                    wrenCnt[k] = 0;
                end
                prevDone[k] = dataDone[k];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic waitDone(input int k);
        int n = 0;
        while (!dataDone[k] && n < 40) begin
            @(posedge Clock); #1;
            n++;
        end
        if (!dataDone[k]) check($sformatf("u%0d DataDone timeout", k), {31'd0, dataDone[k]}, 32'd1);
    endtask

    task automatic access(input int k, input logic wr, input logic rd, input logic [15:0] addr,
                          input logic [15:0] wdat, input logic chk, input logic [15:0] expData,
                          input logic expErr, input int expWren);
        exp_t e;
        e.chk = chk; e.data = expData; e.err = expErr; e.wren = expWren;
        expQ[k].push_back(e);
        dataAddr[k] = addr; dataOut[k] = wdat; writeData[k] = wr; readData[k] = rd;
        @(posedge Clock); #1;
        writeData[k] = 1'b0;
        readData[k]  = 1'b0;
        waitDone(k);
    endtask

    task automatic pushExp(input int k, input logic [15:0] d, input logic err);
        exp_t e;
        e.chk = 1'b1; e.data = d; e.err = err; e.wren = 0;
        expQ[k].push_back(e);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            dataAddr[k] = '0; dataOut[k] = '0; writeData[k] = 1'b0; readData[k] = 1'b0;
        end
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        for (int k = 0; k < N; k++) begin
            check($sformatf("u%0d reset DataDone", k), {31'd0, dataDone[k]}, 32'd1);
            check($sformatf("u%0d reset mem_wren", k), {31'd0, memWren[k]}, 32'd0);
            check($sformatf("u%0d reset proto_err", k), {31'd0, protoErr[k]}, 32'd0);
        end
        check("u0 reset DataIn", {16'd0, dataIn[0]}, 32'd0);
        check("u0 reset mem_addr", {20'd0, memAddr[0]}, 32'd0);
        Reset = 1'b0;
        @(posedge Clock); #1;

        // write then read back, WAIT_CYCLES=1
        access(0, 1, 0, 16'h0010, 16'hBEEF, 0, 16'h0000, 0, 1);
        access(0, 0, 1, 16'h0010, 16'h0000, 1, 16'hBEEF, 0, 0);

        // back-to-back reads with ReadData held across DONE
        access(0, 1, 0, 16'h0001, 16'h1111, 0, 16'h0000, 0, 1);
        access(0, 1, 0, 16'h0002, 16'h2222, 0, 16'h0000, 0, 1);
        pushExp(0, 16'h1111, 1'b0);
        pushExp(0, 16'h2222, 1'b0);
        dataAddr[0] = 16'h0001; readData[0] = 1'b1;
        @(posedge Clock); #1;
        waitDone(0);
        dataAddr[0] = 16'h0002;
        @(posedge Clock); #1;
        check("u0 b2b second accept DataDone", {31'd0, dataDone[0]}, 32'd0);
        readData[0] = 1'b0;
        waitDone(0);

        // out-of-range read, then out-of-range write aliasing address 5
        access(0, 0, 1, 16'hF000, 16'h0000, 1, 16'h0000, 1, 0);
        access(0, 1, 0, 16'h1005, 16'h1234, 0, 16'h0000, 1, 0);

        // simultaneous write+read: write wins, RAM[5] holds 0x00AA
        access(0, 1, 1, 16'h0005, 16'h00AA, 0, 16'h0000, 1, 1);
        access(0, 0, 1, 16'h0005, 16'h0000, 1, 16'h00AA, 1, 0);

        // reset held 3 cycles mid-WAIT
        dataAddr[0] = 16'h0010; readData[0] = 1'b1;
        @(posedge Clock); #1;
        readData[0] = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        check("u0 mid-wait reset DataDone", {31'd0, dataDone[0]}, 32'd1);
        check("u0 mid-wait reset mem_wren", {31'd0, memWren[0]}, 32'd0);
        check("u0 mid-wait reset DataIn", {16'd0, dataIn[0]}, 32'd0);
        check("u0 mid-wait reset proto_err", {31'd0, protoErr[0]}, 32'd0);
        Reset = 1'b0;
        @(posedge Clock); #1;
        access(0, 0, 1, 16'h0010, 16'h0000, 1, 16'hBEEF, 0, 0);

        // latency extremes
        access(1, 1, 0, 16'h0020, 16'h5A5A, 0, 16'h0000, 0, 1);
        access(1, 0, 1, 16'h0020, 16'h0000, 1, 16'h5A5A, 0, 0);
        access(2, 1, 0, 16'h0FFF, 16'hC3C3, 0, 16'h0000, 0, 1);
        access(2, 0, 1, 16'h0FFF, 16'h0000, 1, 16'hC3C3, 0, 0);

        repeat (4) @(posedge Clock);
        #1;
        for (int k = 0; k < N; k++) begin
            check($sformatf("u%0d pending expectations", k), expQ[k].size(), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
